// File: rtl/stage3_execute.sv
`default_nettype none
// ============================================================================
//  Module      : stage3_execute
//  Description : Execute stage of the 32-bit pipelined datapath. Selects
//                operands (with EX-to-EX bypass from its own output register),
//                performs the ALU operation and registers the result and
//                write-back controls as S3_*. Also counts committed writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module stage3_execute #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] S2_readData1,
   input  logic [DATA_W-1:0] S2_readData2,
   input  logic [15:0]       S2_Imm,
   input  logic [2:0]        S2_ALUOp,
   input  logic              S2_DataSource,
   input  logic [4:0]        S2_writeselect,
   input  logic              S2_WriteEnable,
   input  logic [4:0]        S2_readSelect1,
   input  logic [4:0]        S2_readSelect2,
   input  logic              stall,
   input  logic              flush,
   output logic [DATA_W-1:0] S3_ALUOut,
   output logic [4:0]        S3_writeselect,
   output logic              S3_WriteEnable,
   output logic              S3_Zero,
   output logic [CNT_W-1:0]  S3_WriteCount
);

   localparam logic [2:0] c_OP_ADD  = 3'b000;
   localparam logic [2:0] c_OP_SUB  = 3'b001;
   localparam logic [2:0] c_OP_AND  = 3'b010;
   localparam logic [2:0] c_OP_OR   = 3'b011;
   localparam logic [2:0] c_OP_XOR  = 3'b100;
   localparam logic [2:0] c_OP_NOR  = 3'b101;
   localparam logic [2:0] c_OP_SLT  = 3'b110;
   localparam logic [2:0] c_OP_PASS = 3'b111;

   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic              w_fwd_a;
   logic              w_fwd_b;
   logic [DATA_W-1:0] w_imm_ext;
   logic [DATA_W-1:0] w_op_a;
   logic [DATA_W-1:0] w_op_b;
   logic [DATA_W-1:0] w_result;
   logic              w_slt;
   logic              w_advance;

   // Bypass only from a live, non-r0 write held in the output register;
   // while stalled this still compares against the held S3 values.
   assign w_fwd_a = S3_WriteEnable && (S3_writeselect != 5'd0) &&
                    (S3_writeselect == S2_readSelect1);
   assign w_fwd_b = S3_WriteEnable && (S3_writeselect != 5'd0) &&
                    (S3_writeselect == S2_readSelect2);

   assign w_imm_ext = {{(DATA_W-16){S2_Imm[15]}}, S2_Imm};

   assign w_op_a = w_fwd_a ? S3_ALUOut : S2_readData1;
   // The immediate path bypasses the forwarding mux entirely.
   assign w_op_b = S2_DataSource ? w_imm_ext :
                   (w_fwd_b ? S3_ALUOut : S2_readData2);

   assign w_slt = ($signed(w_op_a) < $signed(w_op_b));

   // The stage advances (and the held write commits) unless stalled;
   // a flush overrides a stall, so it also advances.
   assign w_advance = flush || !stall;

   // ALU: combinational, all results wrap modulo 2^DATA_W
   always_comb begin
      w_result = '0;
      case (S2_ALUOp)
         c_OP_ADD:  w_result = w_op_a + w_op_b;
         c_OP_SUB:  w_result = w_op_a - w_op_b;
         c_OP_AND:  w_result = w_op_a & w_op_b;
         c_OP_OR:   w_result = w_op_a | w_op_b;
         c_OP_XOR:  w_result = w_op_a ^ w_op_b;
         c_OP_NOR:  w_result = ~(w_op_a | w_op_b);
         c_OP_SLT:  w_result = {{(DATA_W-1){1'b0}}, w_slt};
         c_OP_PASS: w_result = w_op_b;
         default:   w_result = '0;
      endcase
   end

   // S3 pipeline register: reset > flush (bubble) > stall (hold) > load
   always_ff @(posedge clk) begin
      if (reset) begin
         S3_ALUOut      <= '0;
         S3_writeselect <= 5'd0;
         S3_WriteEnable <= 1'b0;
         S3_Zero        <= 1'b0;
      end else if (flush) begin
         S3_ALUOut      <= '0;
         S3_writeselect <= 5'd0;
         S3_WriteEnable <= 1'b0;
         S3_Zero        <= 1'b0;
      end else if (!stall) begin
         S3_ALUOut      <= w_result;
         S3_writeselect <= S2_writeselect;
         S3_WriteEnable <= S2_WriteEnable && (S2_writeselect != 5'd0);
         S3_Zero        <= (w_result == '0);
      end
   end

   // Retired-write counter: counts the held write as the stage advances
   always_ff @(posedge clk) begin
      if (reset) begin
         S3_WriteCount <= '0;
      end else if (S3_WriteEnable && w_advance) begin
         S3_WriteCount <= S3_WriteCount + c_CNT_ONE;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_stage3_execute.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stage3_execute
//  Description : Scoreboard bench for stage3_execute. A reference model
//                predicts the S3 outputs per edge; a monitor compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stage3_execute;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   logic              clk;
   logic              reset;
   logic [DATA_W-1:0] S2_readData1;
   logic [DATA_W-1:0] S2_readData2;
   logic [15:0]       S2_Imm;
   logic [2:0]        S2_ALUOp;
   logic              S2_DataSource;
   logic [4:0]        S2_writeselect;
   logic              S2_WriteEnable;
   logic [4:0]        S2_readSelect1;
   logic [4:0]        S2_readSelect2;
   logic              stall;
   logic              flush;
   logic [DATA_W-1:0] S3_ALUOut;
   logic [4:0]        S3_writeselect;
   logic              S3_WriteEnable;
   logic              S3_Zero;
   logic [CNT_W-1:0]  S3_WriteCount;

   stage3_execute #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .S2_readData1   (S2_readData1),
      .S2_readData2   (S2_readData2),
      .S2_Imm         (S2_Imm),
      .S2_ALUOp       (S2_ALUOp),
      .S2_DataSource  (S2_DataSource),
      .S2_writeselect (S2_writeselect),
      .S2_WriteEnable (S2_WriteEnable),
      .S2_readSelect1 (S2_readSelect1),
      .S2_readSelect2 (S2_readSelect2),
      .stall          (stall),
      .flush          (flush),
      .S3_ALUOut      (S3_ALUOut),
      .S3_writeselect (S3_writeselect),
      .S3_WriteEnable (S3_WriteEnable),
      .S3_Zero        (S3_Zero),
      .S3_WriteCount  (S3_WriteCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] alu;
      logic [4:0]  ws;
      logic        we;
      logic        z;
      logic [3:0]  cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference state: what the stage architecturally holds after each edge
   logic [31:0] m_alu  = '0;
   logic [4:0]  m_ws   = '0;
   logic        m_we   = 1'b0;
   logic        m_z    = 1'b0;
   int          m_cnt  = 0;

   function automatic logic [31:0] alu_ref(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      int signed sa, sb;
      sa = a;
      sb = b;
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return ~(a | b);
         3'd6: return (sa < sb) ? 32'd1 : 32'd0;
         default: return b;
      endcase
   endfunction

   task automatic set_in(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [15:0] imm,
                         input logic ds, input logic [4:0] ws, input logic we,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic st, input logic fl, input logic rst);
      S2_ALUOp       = op;
      S2_readData1   = a;
      S2_readData2   = b;
      S2_Imm         = imm;
      S2_DataSource  = ds;
      S2_writeselect = ws;
      S2_WriteEnable = we;
      S2_readSelect1 = rs1;
      S2_readSelect2 = rs2;
      stall          = st;
      flush          = fl;
      reset          = rst;
   endtask

   // Predict the next state from the current inputs, clock once, enqueue it
   task automatic cycle();
      exp_t        e;
      logic [31:0] a, b, r;
      if (reset) begin
         m_alu = '0; m_ws = '0; m_we = 1'b0; m_z = 1'b0; m_cnt = 0;
      end else begin
         if (m_we && (flush || !stall)) m_cnt = (m_cnt + 1) % (1 << CNT_W);
         if (flush) begin
            m_alu = '0; m_ws = '0; m_we = 1'b0; m_z = 1'b0;
         end else if (!stall) begin
            a = (m_we && m_ws != 0 && m_ws == S2_readSelect1) ? m_alu : S2_readData1;
            if (S2_DataSource)
               b = {{16{S2_Imm[15]}}, S2_Imm};
            else
               b = (m_we && m_ws != 0 && m_ws == S2_readSelect2) ? m_alu : S2_readData2;
            r     = alu_ref(S2_ALUOp, a, b);
            m_alu = r;
            m_z   = (r == 32'd0);
            m_ws  = S2_writeselect;
            m_we  = S2_WriteEnable && (S2_writeselect != 5'd0);
         end
      end
      e.alu = m_alu; e.ws = m_ws; e.we = m_we; e.z = m_z; e.cnt = 4'(m_cnt);
      @(posedge clk);
      exp_q.push_back(e);
      #1;
   endtask

   task automatic op_cycle(input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] ws,
                           input logic we);
      set_in(op, a, b, 16'h0, 1'b0, ws, we, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      cycle();
   endtask

   // Monitor: the stage presents a new S3 state every cycle
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (S3_ALUOut !== e.alu || S3_writeselect !== e.ws ||
             S3_WriteEnable !== e.we || S3_Zero !== e.z ||
             S3_WriteCount !== e.cnt) begin
            errors++;
            $display("FAIL s3_state t=%0t actual alu=%h ws=%0d we=%b z=%b cnt=%0d required alu=%h ws=%0d we=%b z=%b cnt=%0d",
                     $time, S3_ALUOut, S3_writeselect, S3_WriteEnable, S3_Zero,
                     S3_WriteCount, e.alu, e.ws, e.we, e.z, e.cnt);
         end
      end
   end

   initial begin
      // Reset with arbitrary inputs
      set_in(3'd0, 32'h1234, 32'h5678, 16'hFFFF, 1'b0, 5'd7, 1'b1, 5'd1, 5'd2,
             1'b0, 1'b0, 1'b1);
      cycle();
      cycle();
      // First normal cycle and basic ALU / immediate cases
      op_cycle(3'd0, 32'd5, 32'd7, 5'd3, 1'b1);
      op_cycle(3'd1, 32'd10, 32'd15, 5'd2, 1'b1);
      op_cycle(3'd6, 32'hFFFFFFFF, 32'd1, 5'd4, 1'b1);
      set_in(3'd7, 32'h0, 32'h0, 16'h8000, 1'b1, 5'd6, 1'b1, 5'd0, 5'd0,
             1'b0, 1'b0, 1'b0);
      cycle();
      op_cycle(3'd4, 32'hAAAA5555, 32'hAAAA5555, 5'd7, 1'b1);
      op_cycle(3'd5, 32'h0F0F0000, 32'h000000F0, 5'd8, 1'b1);
      op_cycle(3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 5'd9, 1'b1);
      op_cycle(3'd3, 32'hF0000000, 32'h0000000F, 5'd10, 1'b1);
      // Bypass into operand A, then a r0 target that must not forward
      op_cycle(3'd0, 32'd3, 32'd4, 5'd5, 1'b1);
      set_in(3'd0, 32'd99, 32'd1, 16'h0, 1'b0, 5'd6, 1'b1, 5'd5, 5'd0,
             1'b0, 1'b0, 1'b0);
      cycle();
      op_cycle(3'd0, 32'd3, 32'd4, 5'd0, 1'b1);
      set_in(3'd0, 32'd99, 32'd1, 16'h0, 1'b0, 5'd6, 1'b1, 5'd0, 5'd0,
             1'b0, 1'b0, 1'b0);
      cycle();
      // Bypass on both operands to the same register
      op_cycle(3'd0, 32'd20, 32'd1, 5'd11, 1'b1);
      set_in(3'd0, 32'd0, 32'd0, 16'h0, 1'b0, 5'd12, 1'b1, 5'd11, 5'd11,
             1'b0, 1'b0, 1'b0);
      cycle();
      // Stall for 3 cycles with changing inputs, then release
      op_cycle(3'd0, 32'd2, 32'd2, 5'd1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         set_in(3'd1, $urandom, $urandom, 16'h0, 1'b0, 5'd9, 1'b1, 5'd1, 5'd1,
                1'b1, 1'b0, 1'b0);
         cycle();
      end
      op_cycle(3'd0, 32'd100, 32'd1, 5'd2, 1'b1);
      // Flush together with stall
      set_in(3'd0, 32'd9, 32'd9, 16'h0, 1'b0, 5'd4, 1'b1, 5'd0, 5'd0,
             1'b1, 1'b1, 1'b0);
      cycle();
      op_cycle(3'd0, 32'd1, 32'd1, 5'd3, 1'b1);
      // Counter wrap: reset, then a long run of committed writes
      set_in(3'd0, 32'd0, 32'd0, 16'h0, 1'b0, 5'd1, 1'b1, 5'd0, 5'd0,
             1'b0, 1'b0, 1'b1);
      cycle();
      for (int i = 0; i < 18; i++) op_cycle(3'd0, i, 32'd1, 5'((i % 31) + 1), 1'b1);
      // Randomised traffic with small register indices to exercise bypass
      for (int i = 0; i < 400; i++) begin
         set_in(3'($urandom), $urandom, $urandom, 16'($urandom),
                1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 49) == 0));
         cycle();
      end
      // Let the monitor drain, bounded
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
